// File: rtl/iq_playback_interp.sv
// iq_playback_interp: CPU-loaded I/Q buffer replayed at a paced rate, stream (FIFO) or loop mode.
// Tick -> sync RAM read -> output register, so each tick emits a strobe exactly two cycles later.
module iq_playback_interp #(
  parameter int AW = 13,
  parameter int W  = 16,
  parameter int MI = 16
) (
  input  logic          adc_clk,
  input  logic          reset,
  input  logic          wr_rst,
  input  logic          wr,
  input  logic [W-1:0]  wr_i,
  input  logic [W-1:0]  wr_q,
  input  logic          set_interp,
  input  logic [MI-1:0] interp_in,
  input  logic          start,
  input  logic          stop,
  input  logic          continuous,
  output logic          out_strobe,
  output logic [W-1:0]  out_i,
  output logic [W-1:0]  out_q,
  output logic          busy,
  output logic [AW:0]   count,
  output logic          underrun,
  output logic          overflow
);
  typedef enum logic {IDLE, PLAY} state_t;
  state_t state_q, state_d;
  logic [AW:0] wp_q, wp_d, rp_q, rp_d, len_q, len_d, off_q, off_d;
  logic [AW-1:0] base_q, base_d, raddr;
  logic [MI-1:0] interp_q, interp_d, pace_q, pace_d, interp_m1;
  logic loop_q, loop_d, v1_q, v1_d, z1_q, z1_d, strobe_q, strobe_d, ur_q, ur_d, ov_q, ov_d;
  logic [W-1:0] oi_q, oi_d, oq_q, oq_d;
  logic [2*W-1:0] mem [2**AW];
  logic [2*W-1:0] ram_q;
  logic tick, pop, we, empty, full, zlen, clr;
  assign count = wp_q - rp_q;
  assign busy = state_q == PLAY;
  assign out_strobe = strobe_q;
  assign out_i = oi_q;
  assign out_q = oq_q;
  assign underrun = ur_q;
  assign overflow = ov_q;
  always_comb begin
    empty = count == '0;
    full = count[AW];
    zlen = loop_q && len_q == '0;
    tick = busy && pace_q == '0 && !stop && !zlen;
    pop = tick && !loop_q && !empty;
    clr = wr_rst && !busy;
    we = wr && !clr && !(busy && loop_q) && (!full || pop);
    raddr = loop_q ? base_q + off_q[AW-1:0] : rp_q[AW-1:0];
    interp_m1 = interp_q == '0 ? '0 : interp_q - MI'(1);
    state_d = state_q;
    len_d = len_q;
    base_d = base_q;
    loop_d = loop_q;
    off_d = off_q;
    pace_d = pace_q;
    interp_d = set_interp ? interp_in : interp_q;
    wp_d = we ? wp_q + (AW+1)'(1) : wp_q;
    rp_d = pop ? rp_q + (AW+1)'(1) : rp_q;
    ov_d = ov_q | (wr && !we);
    ur_d = ur_q | (tick && !loop_q && empty);
    v1_d = tick;
    z1_d = tick && !loop_q && empty;
    strobe_d = v1_q && !stop;
    oi_d = strobe_d ? (z1_q ? '0 : ram_q[2*W-1:W]) : oi_q;
    oq_d = strobe_d ? (z1_q ? '0 : ram_q[W-1:0]) : oq_q;
    if (tick) begin
      pace_d = interp_m1;
      off_d = off_q + (AW+1)'(1) == len_q ? '0 : off_q + (AW+1)'(1);
    end else if (busy)
      pace_d = pace_q - MI'(1);
    // Loop window is fixed at start: current fill level starting at the read pointer.
    if (state_q == IDLE) begin
      if (start && !stop) begin
        state_d = PLAY;
        pace_d = '0;
        loop_d = continuous;
        len_d = count;
        base_d = rp_q[AW-1:0];
        off_d = '0;
      end
    end else if (stop || zlen)
      state_d = IDLE;
    if (clr) begin
      wp_d = '0;
      rp_d = '0;
      ov_d = 1'b0;
      ur_d = 1'b0;
    end
  end
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wp_q <= '0;
      rp_q <= '0;
      len_q <= '0;
      off_q <= '0;
      base_q <= '0;
      loop_q <= 1'b0;
      pace_q <= '0;
      interp_q <= MI'(1);
      v1_q <= 1'b0;
      z1_q <= 1'b0;
      strobe_q <= 1'b0;
      oi_q <= '0;
      oq_q <= '0;
      ur_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      len_q <= len_d;
      off_q <= off_d;
      base_q <= base_d;
      loop_q <= loop_d;
      pace_q <= pace_d;
      interp_q <= interp_d;
      v1_q <= v1_d;
      z1_q <= z1_d;
      strobe_q <= strobe_d;
      oi_q <= oi_d;
      oq_q <= oq_d;
      ur_q <= ur_d;
      ov_q <= ov_d;
    end
  end
  always_ff @(posedge adc_clk) begin
    if (we) mem[wp_q[AW-1:0]] <= {wr_i, wr_q};
    ram_q <= mem[raddr];
  end
endmodule

// File: tb/tb_iq_playback_interp.sv
// tb_iq_playback_interp: directed and random stimulus checked each cycle against a queue-based
// model of the buffer, plus literal expectations for the documented scenarios.
module tb_iq_playback_interp;
  localparam int AW = 13, W = 16, MI = 16, DEPTH = 1 << AW;
  logic adc_clk = 0, reset = 0, wr_rst = 0, wr = 0, set_interp = 0, start = 0, stop = 0, continuous = 0;
  logic [W-1:0] wr_i = 0, wr_q = 0;
  logic [MI-1:0] interp_in = 0;
  logic out_strobe, busy, underrun, overflow;
  logic [W-1:0] out_i, out_q;
  logic [AW:0] count;
  int n_cmp = 0, n_bad = 0;
  bit chk_on = 0;

  iq_playback_interp #(.AW(AW), .W(W), .MI(MI)) dut (
    .adc_clk(adc_clk), .reset(reset), .wr_rst(wr_rst), .wr(wr), .wr_i(wr_i), .wr_q(wr_q),
    .set_interp(set_interp), .interp_in(interp_in), .start(start), .stop(stop),
    .continuous(continuous), .out_strobe(out_strobe), .out_i(out_i), .out_q(out_q),
    .busy(busy), .count(count), .underrun(underrun), .overflow(overflow));

  always #5 adc_clk = ~adc_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: buffer as a queue, playback as absolute tick times, strobes as a due-time schedule.
  logic [31:0] fifo[$], snap[$], pend_d[$];
  int pend_due[$];
  bit m_play = 0, m_loop = 0, m_strobe = 0, m_ur = 0, m_ov = 0, tk, pl;
  int m_idx = 0, m_next = 0, m_interp = 1, cyc = 0, cur;
  logic [W-1:0] m_i = 0, m_q = 0;
  logic [31:0] d;

  always @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      fifo.delete(); snap.delete(); pend_due.delete(); pend_d.delete();
      m_play = 0; m_loop = 0; m_interp = 1; m_strobe = 0; m_i = 0; m_q = 0; m_ur = 0; m_ov = 0;
    end else begin
      cur = cyc;
      pl = m_play;
      tk = m_play && cur == m_next && !stop && !(m_loop && snap.size() == 0);
      if (stop) begin pend_due.delete(); pend_d.delete(); end
      if (tk) begin
        if (m_loop) begin d = snap[m_idx]; m_idx = (m_idx + 1) % snap.size(); end
        else if (fifo.size() > 0) d = fifo.pop_front();
        else begin d = 0; m_ur = 1; end
        pend_due.push_back(cur + 2);
        pend_d.push_back(d);
        m_next = cur + (m_interp == 0 ? 1 : m_interp);
      end
      m_strobe = 0;
      if (pend_due.size() > 0 && pend_due[0] == cur + 1) begin
        m_strobe = 1;
        {m_i, m_q} = pend_d[0];
        pend_due.delete(0);
        pend_d.delete(0);
      end
      if (m_play) begin
        if (stop || (m_loop && snap.size() == 0)) m_play = 0;
      end else if (start && !stop) begin
        m_play = 1; m_loop = continuous; snap = fifo; m_idx = 0; m_next = cur + 1;
      end
      if (wr_rst && !pl) begin fifo.delete(); m_ov = 0; m_ur = 0; end
      else if (wr) begin
        if ((pl && m_loop) || fifo.size() >= DEPTH) m_ov = 1;
        else fifo.push_back({wr_i, wr_q});
      end
      if (set_interp) m_interp = int'(interp_in);
      cyc++;
    end
  end

  always @(negedge adc_clk) if (chk_on) begin
    chk("strobe", 32'(out_strobe), 32'(m_strobe));
    chk("out_i", 32'(out_i), 32'(m_i));
    chk("out_q", 32'(out_q), 32'(m_q));
    chk("busy", 32'(busy), 32'(m_play));
    chk("count", 32'(count), fifo.size());
    chk("underrun", 32'(underrun), 32'(m_ur));
    chk("overflow", 32'(overflow), 32'(m_ov));
  end

  task automatic cyc_n(input int n);
    repeat (n) @(negedge adc_clk);
  endtask
  task automatic write_pair(input logic [W-1:0] i, input logic [W-1:0] q);
    wr = 1; wr_i = i; wr_q = q; cyc_n(1); wr = 0;
  endtask
  task automatic set_int(input logic [MI-1:0] v);
    set_interp = 1; interp_in = v; cyc_n(1); set_interp = 0;
  endtask
  task automatic pulse_start(input logic c);
    continuous = c; start = 1; cyc_n(1); start = 0;
  endtask
  task automatic pulse_stop();
    stop = 1; cyc_n(1); stop = 0;
  endtask
  task automatic do_wrrst();
    wr_rst = 1; cyc_n(1); wr_rst = 0;
  endtask

  initial begin
    #2 reset = 1;
    cyc_n(2);
    reset = 0;
    chk_on = 1;
    chk("rst_strobe", 32'(out_strobe), 0);
    chk("rst_out_i", 32'(out_i), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    // Stream at interp=4 then underrun on the fourth tick.
    set_int(4);
    write_pair(16'h0001, 16'hFFFF);
    write_pair(16'h0002, 16'hFFFE);
    write_pair(16'h0003, 16'hFFFD);
    pulse_start(0);
    cyc_n(2);
    chk("s3_strobe", 32'(out_strobe), 1);
    chk("s3_i", 32'(out_i), 32'h0001);
    chk("s3_q", 32'(out_q), 32'hFFFF);
    cyc_n(1);
    chk("s4_nostrobe", 32'(out_strobe), 0);
    chk("s4_hold", 32'(out_i), 32'h0001);
    cyc_n(3);
    chk("s7_i", 32'(out_i), 32'h0002);
    cyc_n(4);
    chk("s11_q", 32'(out_q), 32'hFFFD);
    chk("s11_ur", 32'(underrun), 0);
    cyc_n(4);
    chk("s15_strobe", 32'(out_strobe), 1);
    chk("s15_i", 32'(out_i), 0);
    chk("s15_ur", 32'(underrun), 1);
    chk("s15_count", 32'(count), 0);
    pulse_stop();
    cyc_n(2);
    // Fill to full plus one dropped write, then drain.
    do_wrrst();
    wr = 1;
    for (int i = 0; i <= DEPTH; i++) begin
      wr_i = W'($urandom); wr_q = W'($urandom); cyc_n(1);
    end
    wr = 0;
    chk("full_count", 32'(count), DEPTH);
    chk("full_ovf", 32'(overflow), 1);
    set_int(1);
    pulse_start(0);
    cyc_n(DEPTH + 8);
    chk("drain_count", 32'(count), 0);
    chk("drain_ur", 32'(underrun), 1);
    pulse_stop();
    cyc_n(2);
    // Loop of three with interp_in=0 acting as 1.
    do_wrrst();
    set_int(0);
    write_pair(16'h1111, 16'h8001);
    write_pair(16'h2222, 16'h8002);
    write_pair(16'h3333, 16'h8003);
    pulse_start(1);
    cyc_n(2);
    chk("lp_a", 32'(out_i), 32'h1111);
    cyc_n(1);
    chk("lp_b", 32'(out_q), 32'h8002);
    cyc_n(1);
    chk("lp_c", 32'(out_i), 32'h3333);
    cyc_n(1);
    chk("lp_a2", 32'(out_i), 32'h1111);
    chk("lp_strobe", 32'(out_strobe), 1);
    write_pair(16'h4444, 16'h4444);
    chk("lp_ovf", 32'(overflow), 1);
    chk("lp_count", 32'(count), 3);
    pulse_stop();
    chk("stop_busy", 32'(busy), 0);
    chk("stop_strobe", 32'(out_strobe), 0);
    cyc_n(3);
    // Loop start with empty buffer: busy for one cycle only.
    do_wrrst();
    pulse_start(1);
    chk("zl_busy1", 32'(busy), 1);
    cyc_n(1);
    chk("zl_busy0", 32'(busy), 0);
    cyc_n(3);
    chk("zl_nostrobe", 32'(out_strobe), 0);
    // Asynchronous reset in the middle of playback.
    write_pair(16'h0A0A, 16'h0B0B);
    write_pair(16'h0C0C, 16'h0D0D);
    set_int(2);
    pulse_start(0);
    cyc_n(3);
    chk("pre_rst_busy", 32'(busy), 1);
    #2 reset = 1;
    #1;
    chk("arst_i", 32'(out_i), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_count", 32'(count), 0);
    @(negedge adc_clk);
    reset = 0;
    cyc_n(2);
    // Random traffic.
    for (int k = 0; k < 4000; k++) begin
      wr = 1'($urandom_range(0, 1));
      wr_i = W'($urandom); wr_q = W'($urandom);
      start = $urandom_range(0, 15) == 0;
      stop = $urandom_range(0, 63) == 0;
      continuous = 1'($urandom_range(0, 1));
      set_interp = $urandom_range(0, 31) == 0;
      interp_in = MI'($urandom_range(0, 5));
      wr_rst = $urandom_range(0, 127) == 0;
      cyc_n(1);
    end
    wr = 0; start = 0; stop = 1; set_interp = 0; wr_rst = 0;
    cyc_n(1);
    stop = 0;
    cyc_n(3);
    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
